// File: rtl/taylor_trig_accel_if.sv
// Host-side handshake and data bundle for the Taylor-series trig accelerator.
interface taylor_trig_accel_if #(
  parameter int unsigned W  = 16,
  parameter int unsigned NW = 4
);
  logic                  start;
  logic                  mode;
  logic [W-1:0]          x_in;
  logic [NW-1:0]         n_terms;
  logic                  busy;
  logic                  done;
  logic signed [W+1:0]   result;

  modport master (
    output start, mode, x_in, n_terms,
    input  busy, done, result
  );

  modport slave (
    input  start, mode, x_in, n_terms,
    output busy, done, result
  );
endinterface

// File: rtl/taylor_trig_accel.sv
// Multi-cycle cos/sin evaluator: alternating Taylor series built by repeated
// multiplication by x^2 and a reciprocal coefficient ROM, one term per 3 cycles.
module taylor_trig_accel #(
  parameter int unsigned W         = 16,
  parameter int unsigned MAX_TERMS = 8,
  parameter int unsigned NW        = 4
) (
  input logic                clk,
  input logic                rst,
  taylor_trig_accel_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StMulx,
    StMulc,
    StAcc,
    StDone
  } state_e;

  // ROM entry k: cos divides by (2k+1)(2k+2), sin by (2k+2)(2k+3)
  function automatic logic [W-1:0] coef_calc(input bit sin_mode, input int k);
    longint unsigned den;
    den = sin_mode ? longint'((2 * k + 2) * (2 * k + 3)) : longint'((2 * k + 1) * (2 * k + 2));
    return W'((64'd1 << W) / den);
  endfunction

  logic [W-1:0] w_coef_cos [2**NW];
  logic [W-1:0] w_coef_sin [2**NW];

  for (genvar g = 0; g < 2**NW; g++) begin : g_rom
    if (g < int'(MAX_TERMS) - 1) begin : g_used
      assign w_coef_cos[g] = coef_calc(1'b0, g);
      assign w_coef_sin[g] = coef_calc(1'b1, g);
    end else begin : g_unused
      assign w_coef_cos[g] = '0;
      assign w_coef_sin[g] = '0;
    end
  end

  state_e              r_state, w_state_d;
  logic [W-1:0]        r_x, w_x_d;
  logic                r_mode, w_mode_d;
  logic [NW-1:0]       r_n, w_n_d;
  logic [W-1:0]        r_xsq, w_xsq_d;
  logic [W:0]          r_term, w_term_d;
  logic signed [W+1:0] r_acc, w_acc_d;
  logic [NW-1:0]       r_k, w_k_d;
  logic signed [W+1:0] r_result, w_result_d;

  logic [NW-1:0]       w_n_eff;
  logic [W-1:0]        w_coef;
  logic [2*W-1:0]      w_sq;
  logic [2*W:0]        w_mul_x;
  logic [2*W:0]        w_mul_c;
  logic [W:0]          w_init;
  logic signed [W+1:0] w_term_ext;

  always_comb begin
    if (bus.n_terms == '0) begin
      w_n_eff = NW'(1);
    end else if (bus.n_terms > NW'(MAX_TERMS)) begin
      w_n_eff = NW'(MAX_TERMS);
    end else begin
      w_n_eff = bus.n_terms;
    end
  end

  assign w_coef     = r_mode ? w_coef_sin[r_k] : w_coef_cos[r_k];
  assign w_sq       = r_x * r_x;
  assign w_mul_x    = r_term * r_xsq;
  assign w_mul_c    = r_term * w_coef;
  assign w_init     = r_mode ? {1'b0, r_x} : {1'b1, W'(0)};
  assign w_term_ext = signed'({1'b0, r_term});

  always_comb begin
    w_state_d  = r_state;
    w_x_d      = r_x;
    w_mode_d   = r_mode;
    w_n_d      = r_n;
    w_xsq_d    = r_xsq;
    w_term_d   = r_term;
    w_acc_d    = r_acc;
    w_k_d      = r_k;
    w_result_d = r_result;
    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_x_d     = bus.x_in;
          w_mode_d  = bus.mode;
          w_n_d     = w_n_eff;
          w_state_d = StLoad;
        end
      end
      StLoad: begin
        w_xsq_d  = W'(w_sq >> W);
        w_term_d = w_init;
        w_acc_d  = signed'({1'b0, w_init});
        w_k_d    = '0;
        if (r_n > NW'(1)) begin
          w_state_d = StMulx;
        end else begin
          w_result_d = signed'({1'b0, w_init});
          w_state_d  = StDone;
        end
      end
      StMulx: begin
        w_term_d  = (W+1)'(w_mul_x >> W);
        w_state_d = StMulc;
      end
      StMulc: begin
        w_term_d  = (W+1)'(w_mul_c >> W);
        w_state_d = StAcc;
      end
      StAcc: begin
        // Even k subtracts: the series alternates starting with a minus
        w_acc_d = r_k[0] ? (r_acc + w_term_ext) : (r_acc - w_term_ext);
        w_k_d   = r_k + NW'(1);
        if ((r_k + NW'(2)) < r_n) begin
          w_state_d = StMulx;
        end else begin
          w_result_d = w_acc_d;
          w_state_d  = StDone;
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= StIdle;
      r_x      <= '0;
      r_mode   <= 1'b0;
      r_n      <= '0;
      r_xsq    <= '0;
      r_term   <= '0;
      r_acc    <= '0;
      r_k      <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_d;
      r_x      <= w_x_d;
      r_mode   <= w_mode_d;
      r_n      <= w_n_d;
      r_xsq    <= w_xsq_d;
      r_term   <= w_term_d;
      r_acc    <= w_acc_d;
      r_k      <= w_k_d;
      r_result <= w_result_d;
    end
  end

  assign bus.busy   = (r_state != StIdle);
  assign bus.done   = (r_state == StDone);
  assign bus.result = r_result;

endmodule

// File: tb/tb_taylor_trig_accel.sv
// Directed-vector bench for taylor_trig_accel: latency, results, clamping,
// ignored starts, input stability and asynchronous abort.
module tb_taylor_trig_accel;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  longint last_exp;

  taylor_trig_accel_if #(.W(16), .NW(4)) bus ();

  taylor_trig_accel #(
    .W(16),
    .MAX_TERMS(8),
    .NW(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One transaction; inputs are scrambled and a stray start is pulsed while busy
  task automatic run_op(input logic m, input logic [15:0] x, input logic [3:0] n,
                        input longint exp_res, input int exp_edges, input string tag);
    int edges;
    int busy_ok;
    int hold_ok;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.mode    = m;
    bus.x_in    = x;
    bus.n_terms = n;
    @(posedge clk); #1;
    bus.start = 1'b0;
    edges   = 0;
    busy_ok = 1;
    hold_ok = 1;
    while (!bus.done && edges < 100) begin
      if (!bus.busy) busy_ok = 0;
      if (bus.result !== last_exp) hold_ok = 0;
      bus.x_in    = 16'($urandom);
      bus.mode    = ~m;
      bus.n_terms = 4'($urandom);
      bus.start   = (edges == 2);
      @(posedge clk); #1;
      edges++;
    end
    bus.start = 1'b0;
    check_eq({tag, "/edges"}, edges, exp_edges);
    check_eq({tag, "/result"}, bus.result, exp_res);
    check_eq({tag, "/busy_run"}, busy_ok, 1);
    check_eq({tag, "/result_hold"}, hold_ok, 1);
    check_eq({tag, "/busy_done"}, bus.busy, 1);
    // Start during the done cycle must not be accepted
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_eq({tag, "/busy_after"}, bus.busy, 0);
    check_eq({tag, "/done_after"}, bus.done, 0);
    check_eq({tag, "/result_after"}, bus.result, exp_res);
    last_exp = exp_res;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    last_exp    = 0;
    rst         = 1'b0;
    bus.start   = 1'b0;
    bus.mode    = 1'b0;
    bus.x_in    = '0;
    bus.n_terms = '0;
    #2;
    check_eq("reset/busy", bus.busy, 0);
    check_eq("reset/done", bus.done, 0);
    check_eq("reset/result", bus.result, 0);
    @(negedge clk);
    rst = 1'b1;

    run_op(1'b0, 16'd0,     4'd4,  65536, 10, "cos_x0_n4");
    run_op(1'b0, 16'd32768, 4'd1,  65536, 1,  "cos_half_n1");
    run_op(1'b0, 16'd32768, 4'd2,  57344, 4,  "cos_half_n2");
    run_op(1'b1, 16'd32768, 4'd1,  32768, 1,  "sin_half_n1");
    run_op(1'b1, 16'd32768, 4'd2,  31403, 4,  "sin_half_n2");
    run_op(1'b0, 16'd32768, 4'd0,  65536, 1,  "cos_half_n0");
    run_op(1'b1, 16'd0,     4'd3,  0,     7,  "sin_x0_n3");
    run_op(1'b0, 16'd32768, 4'd15, 57513, 22, "cos_half_n15");
    run_op(1'b0, 16'd32768, 4'd3,  57514, 7,  "cos_half_n3");

    // Abort in MULC: two edges after the sampling edge
    @(negedge clk);
    bus.start   = 1'b1;
    bus.mode    = 1'b0;
    bus.x_in    = 16'd32768;
    bus.n_terms = 4'd8;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("abort/busy_before", bus.busy, 1);
    check_eq("abort/result_before", bus.result, 57514);
    #2;
    rst = 1'b0;
    #1;
    check_eq("abort/busy", bus.busy, 0);
    check_eq("abort/done", bus.done, 0);
    check_eq("abort/result", bus.result, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("abort/done_held", bus.done, 0);
    @(negedge clk);
    rst = 1'b1;
    last_exp = 0;
    run_op(1'b0, 16'd0, 4'd1, 65536, 1, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
